address_encoder: RTL and testbench

ADDRESS_ENCODER -- requirements
Module: address_encoder

---
 rtl/address_encoder_pkg.sv | 30 +++
 rtl/address_encoder_frame_fifo.sv | 84 ++++++++
 rtl/address_encoder.sv | 197 +++++++++++++++++++
 tb/tb_address_encoder.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/address_encoder_pkg.sv
// Shared frame-protocol definitions for the address encoder and the frame decoder:
// output FSM state encodings, frame field positions, default transmit timeout
// and a frame packing helper.
package address_encoder_pkg;

    localparam int FRAME_W  = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 4;
    localparam int DATA_MSB = 3;
    localparam int DATA_LSB = 0;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } enc_state_e;

    // Place register address and data into their frame fields.
    function automatic logic [FRAME_W-1:0] pack_frame(input logic [3:0] addr,
                                                      input logic [3:0] dat);
        logic [FRAME_W-1:0] f;
        f = {FRAME_W{1'b0}};
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = dat;
        return f;
    endfunction

endpackage

// File: rtl/address_encoder_frame_fifo.sv
// frame_fifo: synchronous FIFO of WIDTH-bit frames, DEPTH entries (power of two).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// full/empty are registered from the next-state pointers.
module frame_fifo
    import address_encoder_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push_s, do_pop_s;

    // Qualify push/pop against the current (pre-pop) occupancy and compute next pointers.
    always_comb begin
        do_push_s = push_i & ~full_q;
        do_pop_s  = pop_i & ~empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if ((wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            full_d = 1'b1;
        end else begin
            full_d = 1'b0;
        end
        if (wr_ptr_d == rd_ptr_d) begin
            empty_d = 1'b1;
        end else begin
            empty_d = 1'b0;
        end
    end

    // Pointer and status flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/address_encoder.sv
// address_encoder: accepts {address,data} register writes from a producer with a
// valid/ack handshake, queues them in a frame_fifo and presents them one at a
// time to a byte transmitter (frame_valid held until tx_ack, then one gap cycle).
// Optional build macro ADDRESS_ENCODER_TIMEOUT_EN: drop a frame that has waited
// TIMEOUT cycles in SEND without tx_ack and pulse 'dropped'.
module address_encoder
    import address_encoder_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         address,
    input  logic [3:0]         data,
    input  logic               valid,
    output logic               ack,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    input  logic               tx_ack,
    output logic               full,
    output logic               dropped
);

    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("address_encoder: DEPTH must be a power of two in 2..16");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("address_encoder: TIMEOUT must be in 1..255");
    end

    enc_state_e         state_q, state_d;
    logic               armed_q, armed_d;
    logic               ack_q, ack_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               frame_valid_q, frame_valid_d;
    logic               accept_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic               timeout_s;
    logic [FRAME_W-1:0] head_s;

    frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (accept_s),
        .wr_data_i (pack_frame(address, data)),
        .pop_i     (pop_s),
        .rd_data_o (head_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

    // Producer side: one accepted entry per valid assertion; re-arm only once valid drops.
    always_comb begin
        accept_s = valid & armed_q & ~full_s;
        ack_d    = accept_s;
        if (accept_s) begin
            armed_d = 1'b0;
        end else if (!valid) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // Producer handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            ack_q   <= ack_d;
        end
    end

`ifdef ADDRESS_ENCODER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       dropped_q, dropped_d;

    // SEND-cycle counter: counts completed SEND cycles, cleared whenever SEND is left.
    always_comb begin
        if ((state_q == ST_SEND) && (cnt_q == TIMEOUT_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        if ((state_q == ST_SEND) && (state_d == ST_SEND)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
        if (timeout_s && !tx_ack) begin
            dropped_d = 1'b1;
        end else begin
            dropped_d = 1'b0;
        end
    end

    // Timeout counter and drop pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            dropped_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
        end
    end

    assign dropped = dropped_q;
`else
    assign timeout_s = 1'b0;
    assign dropped   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: tx_ack is only meaningful in SEND and beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_ack) begin
                    state_d = ST_GAP;
                end else if (timeout_s) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: pop the head while idle, frame_valid registered from the next state.
    always_comb begin
        if ((state_q == ST_IDLE) && !empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (pop_s) begin
            frame_d = head_s;
        end else begin
            frame_d = frame_q;
        end
        if (state_d == ST_SEND) begin
            frame_valid_d = 1'b1;
        end else begin
            frame_valid_d = 1'b0;
        end
    end

    // Frame output registers; frame stays stable for the whole SEND period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q       <= {FRAME_W{1'b0}};
            frame_valid_q <= 1'b0;
        end else begin
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign ack         = ack_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign full        = full_s;

endmodule

// File: tb/tb_address_encoder.sv
// Self-checking bench for address_encoder (DEPTH=4). Expected frames go into a
// scoreboard queue when a request is driven and are compared when the encoder
// hands the frame over (tx_ack) or drops it. With ADDRESS_ENCODER_TIMEOUT_EN a
// second instance with TIMEOUT=8 exercises the drop path.
module tb_address_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] address;
    logic [3:0] data;
    logic       valid;
    logic       ack;
    logic [7:0] frame;
    logic       frame_valid;
    logic       tx_ack;
    logic       full;
    logic       dropped;

    int n_vec = 0;
    int n_err = 0;

    // transmitter model: 0 = never ack, 1 = ack after ack_delay cycles of frame_valid, 2 = manual
    int   tx_mode   = 0;
    int   ack_delay = 0;
    int   fv_run    = 0;
    logic auto_ack  = 1'b0;
    logic man_ack   = 1'b0;

    assign tx_ack = (tx_mode == 2) ? man_ack : auto_ack;

    logic [7:0] sb_q[$];
    logic       mon_en     = 1'b1;
    int         ack_total  = 0;
    int         drop_total = 0;

    address_encoder #(
        .DEPTH   (4),
        .TIMEOUT (255)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .data        (data),
        .valid       (valid),
        .ack         (ack),
        .frame       (frame),
        .frame_valid (frame_valid),
        .tx_ack      (tx_ack),
        .full        (full),
        .dropped     (dropped)
    );

`ifdef ADDRESS_ENCODER_TIMEOUT_EN
    logic       t_valid   = 1'b0;
    logic       t_tx_ack  = 1'b0;
    logic       t_ack;
    logic [7:0] t_frame;
    logic       t_fv;
    logic       t_full;
    logic       t_dropped;

    address_encoder #(
        .DEPTH   (4),
        .TIMEOUT (8)
    ) u_dut_to (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .data        (data),
        .valid       (t_valid),
        .ack         (t_ack),
        .frame       (t_frame),
        .frame_valid (t_fv),
        .tx_ack      (t_tx_ack),
        .full        (t_full),
        .dropped     (t_dropped)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, wait up to max_cyc cycles for ack, then drop valid for a cycle.
    task automatic send_req(input logic [3:0] a, input logic [3:0] d, input int max_cyc,
                            output bit got);
        address = a;
        data    = d;
        valid   = 1'b1;
        sb_q.push_back({a, d});
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            step();
            if (ack) got = 1'b1;
        end
        valid = 1'b0;
        step();
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check(name, sb_q.size(), 0);
        repeat (3) step();
    endtask

    // Transmitter responder, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (frame_valid) fv_run = fv_run + 1;
            else fv_run = 0;
            auto_ack = (tx_mode == 1) && frame_valid && (fv_run >= ack_delay + 1);
        end
    end

    // Output monitor on the falling edge: scoreboard compare, ack pulse width, gap, stability.
    initial begin
        logic       ack_prev, fv_prev, hs_prev;
        logic [7:0] frame_prev;
        ack_prev = 1'b0; fv_prev = 1'b0; hs_prev = 1'b0; frame_prev = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (ack) check("ack_one_cycle", ack_prev, 1'b0);
                if (hs_prev) check("gap_after_tx_ack", frame_valid, 1'b0);
                if (frame_valid && fv_prev) check("frame_stable", frame, frame_prev);
                if (frame_valid && tx_ack) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got %0h, expected none", frame);
                    end else begin
                        check("frame_out", frame, sb_q.pop_front());
                    end
                end
                if (dropped) begin
                    check("drop_fv_low", frame_valid, 1'b0);
                    if (sb_q.size() != 0) check("dropped_frame", frame, sb_q.pop_front());
                end
            end
            if (ack) ack_total++;
            if (dropped) drop_total++;
            ack_prev   = ack;
            fv_prev    = frame_valid;
            frame_prev = frame;
            hs_prev    = frame_valid && tx_ack;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] addr;
        logic [3:0] dat;
        int         hold;
        int         ack_dly;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit   got;
        int   cyc, lat, a0, cnt, miss, full_seen, fvc, drops;

        vecs[0] = '{addr: 4'hA, dat: 4'h5, hold: 3,  ack_dly: 2, exp: 8'hA5};
        vecs[1] = '{addr: 4'h0, dat: 4'h0, hold: 1,  ack_dly: 0, exp: 8'h00};
        vecs[2] = '{addr: 4'hF, dat: 4'hF, hold: 2,  ack_dly: 1, exp: 8'hFF};
        vecs[3] = '{addr: 4'h3, dat: 4'hC, hold: 20, ack_dly: 4, exp: 8'h3C};
        vecs[4] = '{addr: 4'h8, dat: 4'h1, hold: 5,  ack_dly: 0, exp: 8'h81};

        rst = 1'b1; valid = 1'b0; address = 4'h0; data = 4'h0;
        repeat (3) step();
        check("rst_ack", ack, 1'b0);
        check("rst_frame", frame, 8'h00);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_dropped", dropped, 1'b0);
        rst = 1'b0;
        repeat (2) step();

        // Table vectors: single requests, various valid hold lengths and tx_ack delays.
        for (int k = 0; k < 5; k++) begin
            ack_delay = vecs[k].ack_dly;
            tx_mode   = 1;
            address   = vecs[k].addr;
            data      = vecs[k].dat;
            valid     = 1'b1;
            sb_q.push_back(vecs[k].exp);
            a0  = ack_total;
            cyc = 0;
            lat = 0;
            while ((cyc < vecs[k].hold || sb_q.size() != 0) && cyc < 300) begin
                step();
                cyc++;
                if (cyc == vecs[k].hold) valid = 1'b0;
                if (lat == 1) begin
                    check("latency_fv_high", frame_valid, 1'b1);
                    lat = 2;
                end
                if (ack && lat == 0) begin
                    check("latency_fv_low_at_ack", frame_valid, 1'b0);
                    lat = 1;
                end
            end
            check("vec_drained", sb_q.size(), 0);
            repeat (3) step();
            check("vec_ack_count", ack_total - a0, 1);
            check("vec_not_full", full, 1'b0);
        end

        // Fill: transmitter stalled. The first frame moves into the frame register,
        // so five requests are acked and the FIFO then holds four and reports full.
        tx_mode = 0;
        a0 = ack_total;
        for (int i = 0; i < 5; i++) begin
            send_req(4'h1, 4'(i), 8, got);
            check("fill_ack", got, 1'b1);
        end
        check("fill_full", full, 1'b1);
        address = 4'h1; data = 4'h5; valid = 1'b1;
        sb_q.push_back(8'h15);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack) cnt++;
        end
        check("fill_wait_noack", cnt, 0);
        check("fill_head_frame", frame, 8'h10);
        check("fill_head_valid", frame_valid, 1'b1);
        tx_mode = 2; man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ack) got = 1'b1;
        end
        check("fill_late_ack", got, 1'b1);
        valid = 1'b0;
        step();
        tx_mode = 1; ack_delay = 1;
        drain("fill_drain", 200);
        check("fill_ack_total", ack_total - a0, 6);
        check("fill_not_full", full, 1'b0);

        // Push/pop steady state at FIFO occupancy 2 across pointer wrap.
        tx_mode = 0;
        for (int i = 0; i < 3; i++) begin
            send_req(4'h3, 4'(i), 8, got);
            check("pp_prime_ack", got, 1'b1);
        end
        tx_mode = 1; ack_delay = 0;
        miss = 0; full_seen = 0;
        for (int i = 0; i < 10; i++) begin
            address = 4'h4; data = 4'(i); valid = 1'b1;
            sb_q.push_back({4'h4, 4'(i)});
            step();
            if (!ack) miss++;
            if (full) full_seen++;
            valid = 1'b0;
            step();
            if (full) full_seen++;
            step();
            if (full) full_seen++;
        end
        check("pp_all_acked", miss, 0);
        check("pp_never_full", full_seen, 0);
        drain("pp_drain", 200);

`ifndef ADDRESS_ENCODER_TIMEOUT_EN
        // Without the timeout feature a frame waits in SEND indefinitely.
        tx_mode = 0;
        send_req(4'h9, 4'h9, 8, got);
        check("hold_ack", got, 1'b1);
        drops = drop_total;
        repeat (300) step();
        check("hold_no_drop", drop_total - drops, 0);
        check("hold_fv", frame_valid, 1'b1);
        tx_mode = 1; ack_delay = 0;
        drain("hold_drain", 50);
`endif

        // Reset in the middle of SEND with three entries queued behind it.
        tx_mode = 0;
        for (int i = 0; i < 4; i++) begin
            send_req(4'h2, 4'(i), 8, got);
            check("rmid_ack", got, 1'b1);
        end
        check("rmid_sending", frame_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rmid_fv_async", frame_valid, 1'b0);
        check("rmid_full_async", full, 1'b0);
        mon_en = 1'b0;
        sb_q.delete();
        repeat (2) step();
        rst = 1'b0;
        tx_mode = 1; ack_delay = 0;
        a0 = ack_total; fvc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (frame_valid) fvc++;
        end
        mon_en = 1'b1;
        check("rmid_no_frames", fvc, 0);
        check("rmid_no_ack", ack_total - a0, 0);
        send_req(4'h7, 4'hE, 8, got);
        check("rmid_new_ack", got, 1'b1);
        drain("rmid_drain", 50);

`ifdef ADDRESS_ENCODER_TIMEOUT_EN
        // TIMEOUT=8 instance: first frame dropped after 8 SEND cycles, second acked on cycle 8.
        begin
            int phase, run, nrun, gapc;
            address = 4'hC; data = 4'h1; t_valid = 1'b1;
            phase = 0; run = 0; nrun = 0; gapc = 0; drops = 0;
            for (int i = 0; i < 60; i++) begin
                step();
                t_tx_ack = 1'b0;
                if (phase == 0 && t_ack) begin
                    t_valid = 1'b0; phase = 1;
                end else if (phase == 1) begin
                    data = 4'h2; t_valid = 1'b1; phase = 2;
                end else if (phase == 2 && t_ack) begin
                    t_valid = 1'b0; phase = 3;
                end
                if (t_dropped) drops++;
                if (t_fv) begin
                    if (run == 0) begin
                        check("to_frame", t_frame, (nrun == 0) ? 8'hC1 : 8'hC2);
                        if (nrun == 1) check("to_gap_cycles", gapc, 2);
                    end
                    run++;
                    if (nrun == 1 && run == 8) t_tx_ack = 1'b1;
                end else if (run != 0) begin
                    check("to_send_cycles", run, 8);
                    check("to_drop_pulse", t_dropped, (nrun == 0) ? 1'b1 : 1'b0);
                    nrun++;
                    run  = 0;
                    gapc = 1;
                end else begin
                    gapc++;
                end
            end
            check("to_drop_count", drops, 1);
            check("to_frames_seen", nrun, 2);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
